// File: rtl/key_event_ctrl.sv
// Keypad event controller: expands per-row new-press masks into 4-bit key codes
// and queues them in a FIFO drained through a valid/ready handshake.
module key_event_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     row_rdy,
    input  logic [1:0]               hi,
    input  logic [3:0]               col_out,
    output logic                     key_valid,
    output logic [3:0]               key_code,
    input  logic                     key_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     ovf,
    input  logic                     clr_ovf,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SAMPLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [3:0]    mask_q, mask_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [3:0]    mem_q [DEPTH];
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic          ovf_q, ovf_d;
    logic          push_req, do_push, do_pop, full, collide;
    logic [3:0]    push_code;

    // Scan FSM: one SAMPLE cycle, then four SCAN cycles walking the columns.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        row_d     = row_q;
        col_idx_d = col_idx_q;
        push_req  = 1'b0;
        collide   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (row_rdy && en) state_d = SAMPLE;
            end
            SAMPLE: begin
                mask_d  = col_out;
                row_d   = hi;
                collide = row_rdy && en;
                if (col_out == 4'hF) begin
                    state_d = IDLE;
                end else begin
                    col_idx_d = 2'd0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                collide   = row_rdy && en;
                push_req  = !mask_q[col_idx_q];
                col_idx_d = col_idx_q + 2'd1;
                if (col_idx_q == 2'd3) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_code = {row_q, col_idx_q};

    // FIFO bookkeeping; a pop in the same cycle frees the slot for a push at full.
    always_comb begin
        full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
        do_pop  = valid_q && key_ready;
        do_push = push_req && (!full || do_pop);
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        valid_d = (count_d != '0);
        code_d  = code_q;
        if (do_push && (count_q == {{AW{1'b0}}, do_pop})) begin
            code_d = push_code;
        end else if (count_d != '0) begin
            code_d = mem_q[rptr_d[AW-1:0]];
        end
        ovf_d = ovf_q;
        if (collide || (push_req && !do_push)) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= 4'd0;
            row_q     <= 2'd0;
            col_idx_q <= 2'd0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            row_q     <= row_d;
            col_idx_q <= col_idx_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_code;
    end

    assign key_valid  = valid_q;
    assign key_code   = code_q;
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign irq        = valid_q;

endmodule
